// File: rtl/mux_nne1_regjistruar_pkg.sv
// Shared constants and helpers for the registered N:1 multiplexer.
package pkg_mux;

  localparam logic MODE_DIREKT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Ceiling log2, used to size select and channel-index fields.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_nne1_regjistruar_rr_prioritet.sv
// Round-robin priority search: first requesting channel at or after ptr.
module rr_prioritet
  import pkg_mux::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned SW = clog2(N)
) (
  input  logic [N-1:0]  kerkesa,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic [N-1:0]  grant,
  output logic          any_grant
);

  // Requests are rotated so ptr lands at bit 0; the first set bit is the winner.
  always_comb begin
    logic [2*N-1:0] dbl;
    int unsigned    sum;
    dbl       = {kerkesa, kerkesa} >> ptr;
    sum       = 0;
    idx       = '0;
    any_grant = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_grant && dbl[i]) begin
        any_grant = 1'b1;
        sum       = i + 32'(ptr);
        idx       = (sum >= N) ? SW'(sum - N) : SW'(sum);
      end
    end
    grant = any_grant ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/mux_nne1_regjistruar.sv
// N-channel, W-bit registered multiplexer with valid/ready handshake,
// direct or round-robin selection.
module mux_nne1_regjistruar
  import pkg_mux::*;
#(
  parameter  int unsigned W  = 24,
  parameter  int unsigned N  = 8,
  localparam int unsigned SW = clog2(N)
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [N*W-1:0] Hyrjet,
  input  logic [N-1:0]   Valid_in,
  output logic [N-1:0]   Ready_in,
  input  logic [SW-1:0]  S,
  input  logic           Mode,
  output logic [W-1:0]   Dalja,
  output logic           Valid_out,
  input  logic           Ready_out,
  output logic [SW-1:0]  Zgjedhja
);

  logic          ld;
  logic [SW-1:0] ptr;
  logic [SW-1:0] rr_idx;
  logic [N-1:0]  rr_1h;
  logic          rr_any;
  logic          gnt;
  logic [SW-1:0] g_idx;
  logic [W-1:0]  sel_data;

  // Output register can take a beat when empty or being drained this cycle.
  assign ld = !Valid_out || Ready_out;

  rr_prioritet #(.N(N)) u_rr (
    .kerkesa   (Valid_in),
    .ptr       (ptr),
    .idx       (rr_idx),
    .grant     (rr_1h),
    .any_grant (rr_any)
  );

  // Arbitration: pick the granted channel and drive the one-hot accept.
  always_comb begin
    gnt      = 1'b0;
    g_idx    = '0;
    Ready_in = '0;
    if (Reset && ld) begin
      if (Mode == MODE_RR) begin
        gnt      = rr_any;
        g_idx    = rr_idx;
        Ready_in = rr_1h;
      end else if (32'(S) < N) begin
        g_idx    = S;
        gnt      = |(Valid_in & (N'(1) << S));
        Ready_in = gnt ? (N'(1) << S) : '0;
      end
    end
  end

  // Data path select for the granted channel.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(g_idx) == k) sel_data = Hyrjet[k*W +: W];
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Dalja     <= '0;
      Valid_out <= 1'b0;
      Zgjedhja  <= '0;
      ptr       <= '0;
    end else begin
      if (ld) begin
        Valid_out <= gnt;
        if (gnt) begin
          Dalja    <= sel_data;
          Zgjedhja <= g_idx;
        end
      end
      if (gnt && (Mode == MODE_RR)) begin
        ptr <= (32'(g_idx) == N - 1) ? '0 : g_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_nne1_regjistruar.sv
// Self-checking bench for mux_nne1_regjistruar (N=8 and N=5 instances).
module tb_mux_nne1_regjistruar;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [191:0] hyr;
  logic [7:0]   vin, rin;
  logic [2:0]   s, zg;
  logic         mode, rdy, vout;
  logic [23:0]  dalja;

  logic [119:0] h5;
  logic [4:0]   v5, r5;
  logic [2:0]   s5, z5;
  logic         m5, rdy5, vout5;
  logic [23:0]  d5;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [26:0] q[$];
  int          m_ptr;
  bit          m_vout;

  mux_nne1_regjistruar #(.W(24), .N(8)) dut (
    .Clock(clk), .Reset(rst_n), .Hyrjet(hyr), .Valid_in(vin), .Ready_in(rin),
    .S(s), .Mode(mode), .Dalja(dalja), .Valid_out(vout), .Ready_out(rdy),
    .Zgjedhja(zg)
  );

  mux_nne1_regjistruar #(.W(24), .N(5)) dut5 (
    .Clock(clk), .Reset(rst_n), .Hyrjet(h5), .Valid_in(v5), .Ready_in(r5),
    .S(s5), .Mode(m5), .Dalja(d5), .Valid_out(vout5), .Ready_out(rdy5),
    .Zgjedhja(z5)
  );

  function automatic int model_grant(logic [7:0] v, logic [2:0] sel, logic m, int p, bit ld);
    if (!ld) return -1;
    if (!m) return v[sel] ? int'(sel) : -1;
    for (int i = 0; i < 8; i++) begin
      if (v[(p + i) % 8]) return (p + i) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] onehot(int g);
    return (g < 0) ? 8'h00 : (8'h01 << g);
  endfunction

  task automatic fill_data();
    for (int k = 0; k < 8; k++) hyr[k*24 +: 24] = 24'($urandom);
  endtask

  // Clock one edge and advance the reference state of the N=8 instance.
  task automatic advance(input int g);
    bit ld;
    ld = !m_vout || rdy;
    @(posedge clk);
    if (m_vout && rdy && q.size() > 0) void'(q.pop_front());
    if (ld) begin
      m_vout = (g >= 0);
      if (g >= 0) q.push_back({hyr[g*24 +: 24], 3'(g)});
    end
    if (mode && g >= 0) m_ptr = (g + 1) % 8;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vin = 8'hFF; rdy = 1'b1; mode = 1'b0; s = 3'd0; fill_data();
    v5 = '0; s5 = '0; m5 = 1'b0; rdy5 = 1'b1; h5 = '0;
    m_ptr = 0; m_vout = 1'b0; q.delete();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({dalja, vout, zg, rin} !== '0)
      $display("FAIL reset_state: dalja=%h vout=%b sel=%0d rdy_in=%h required all zero", dalja, vout, zg, rin);
    else pass_cnt++;
    rst_n = 1'b1; vin = 8'h00;
  endtask

  task automatic test_direct();
    int g;
    mode = 1'b0; s = 3'd3; vin = 8'h08; rdy = 1'b1; fill_data();
    hyr[3*24 +: 24] = 24'hABCDEF;
    #1;
    g = model_grant(vin, s, mode, m_ptr, !m_vout || rdy);
    total_cnt++;
    if (rin !== 8'h08) $display("FAIL direct_ready: got %h required 08", rin);
    else pass_cnt++;
    advance(g);
    total_cnt++;
    if (vout !== 1'b1 || dalja !== 24'hABCDEF || zg !== 3'd3)
      $display("FAIL direct_out: vout=%b data=%h sel=%0d required 1 abcdef 3", vout, dalja, zg);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int g;
    mode = 1'b0; s = 3'd3; vin = 8'hFF;
    for (int c = 0; c < 8; c++) begin
      rdy = (c >= 4); fill_data();
      #1;
      g = model_grant(vin, s, mode, m_ptr, !m_vout || rdy);
      total_cnt++;
      if (rin !== onehot(g)) $display("FAIL bp_ready[%0d]: got %h required %h", c, rin, onehot(g));
      else pass_cnt++;
      advance(g);
      total_cnt++;
      if (vout !== m_vout || (m_vout && {dalja, zg} !== q[0]))
        $display("FAIL bp_out[%0d]: vout=%b data=%h sel=%0d required vout=%b data=%h sel=%0d",
                 c, vout, dalja, zg, m_vout, q[0][26:3], q[0][2:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_rr();
    int g;
    mode = 1'b1; vin = 8'hFF; rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      fill_data();
      #1;
      g = model_grant(vin, s, mode, m_ptr, !m_vout || rdy);
      total_cnt++;
      if (rin !== (8'h01 << (i % 8))) $display("FAIL rr_ready[%0d]: got %h required %h", i, rin, 8'h01 << (i % 8));
      else pass_cnt++;
      advance(g);
      total_cnt++;
      if (vout !== 1'b1 || zg !== 3'(i % 8) || {dalja, zg} !== q[0])
        $display("FAIL rr_out[%0d]: vout=%b data=%h sel=%0d required 1 %h %0d", i, vout, dalja, zg, q[0][26:3], i % 8);
      else pass_cnt++;
    end
  endtask

  task automatic test_rr_skip();
    int g;
    logic [7:0] vt[4] = '{8'h20, 8'h05, 8'h05, 8'hFF};
    logic [7:0] et[4] = '{8'h20, 8'h01, 8'h04, 8'h08};
    mode = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vin = vt[i]; fill_data();
      #1;
      g = model_grant(vin, s, mode, m_ptr, !m_vout || rdy);
      total_cnt++;
      if (rin !== et[i] || rin !== onehot(g)) $display("FAIL rr_skip_ready[%0d]: got %h required %h", i, rin, et[i]);
      else pass_cnt++;
      advance(g);
      total_cnt++;
      if (vout !== m_vout || {dalja, zg} !== q[0])
        $display("FAIL rr_skip_out[%0d]: vout=%b data=%h sel=%0d required vout=%b data=%h sel=%0d",
                 i, vout, dalja, zg, m_vout, q[0][26:3], q[0][2:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int g;
    rdy = 1'b0; vin = 8'hFF; mode = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({dalja, vout, zg, rin} !== '0)
      $display("FAIL reset_mid: dalja=%h vout=%b sel=%0d rdy_in=%h required all zero", dalja, vout, zg, rin);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    q.delete(); m_vout = 1'b0; m_ptr = 0;
    rdy = 1'b1; fill_data();
    #1;
    g = model_grant(vin, s, mode, m_ptr, !m_vout || rdy);
    total_cnt++;
    if (rin !== 8'h01) $display("FAIL reset_ptr: got %h required 01", rin);
    else pass_cnt++;
    advance(g);
    total_cnt++;
    if (vout !== 1'b1 || {dalja, zg} !== q[0])
      $display("FAIL reset_out: vout=%b data=%h sel=%0d required 1 %h %0d", vout, dalja, zg, q[0][26:3], q[0][2:0]);
    else pass_cnt++;
    vin = 8'h00;
  endtask

  task automatic test_n5_out_of_range();
    logic [23:0] held;
    for (int k = 0; k < 5; k++) h5[k*24 +: 24] = 24'($urandom);
    held = h5[2*24 +: 24];
    m5 = 1'b0; s5 = 3'd2; v5 = 5'h1F; rdy5 = 1'b0;
    #1;
    total_cnt++;
    if (r5 !== 5'h04) $display("FAIL n5_load_ready: got %h required 04", r5);
    else pass_cnt++;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) h5[k*24 +: 24] = 24'($urandom);
    total_cnt++;
    if (vout5 !== 1'b1 || d5 !== held || z5 !== 3'd2)
      $display("FAIL n5_load_out: vout=%b data=%h sel=%0d required 1 %h 2", vout5, d5, z5, held);
    else pass_cnt++;
    s5 = 3'd6;
    for (int c = 0; c < 2; c++) begin
      rdy5 = (c == 1);
      #1;
      total_cnt++;
      if (r5 !== 5'h00) $display("FAIL n5_oor_ready[%0d]: got %h required 00", c, r5);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (vout5 !== (c == 0) || d5 !== held || z5 !== 3'd2)
        $display("FAIL n5_oor_out[%0d]: vout=%b data=%h sel=%0d required %b %h 2", c, vout5, d5, z5, c == 0, held);
      else pass_cnt++;
    end
    v5 = '0;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_backpressure();
    test_rr();
    test_rr_skip();
    test_reset_mid();
    test_n5_out_of_range();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
